fp_mul_pipe: RTL and testbench

Pipelined, parametrised floating-point multiplier: the next generation of the combinational bfloat16 multiplier. It accepts one operand pair per cycle over a valid/ready handshake and returns a correctly classified, rounded product after three register stages. IEEE-style special-case handling covers zero, infinity and NaN, with subnormals flushed, and each result carries sticky-free per-result exception flags. The block sits between the operand issue logic and the result writeback/accumulate path of the FPU.

---
 rtl/fp_mul_pipe_pkg.sv | 34 +++
 rtl/fp_mul_pipe_classify.sv | 33 +++
 rtl/fp_mul_pipe.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mul_pipe_pkg.sv
// Shared FPU types for the pipelined multiplier.
// Operand classes, packed fp layout, bias and canonical qNaN.
package fp_mul_pipe_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 7;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } fp_cls_e;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_FRAC_W-1:0] frac;
  } fp_t;

  function automatic int f_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  localparam int FP_BIAS = f_bias(FP_EXP_W);

  localparam fp_t FP_QNAN = fp_t'({
    1'b0,
    {FP_EXP_W{1'b1}},
    1'b1,
    {(FP_FRAC_W-1){1'b0}}
  });

endpackage

// File: rtl/fp_mul_pipe_classify.sv
// Operand classifier: zero (incl. subnormal), inf, NaN, normal.
// Purely combinational, used twice in the first stage.
module fp_classify
  import fp_mul_pipe_pkg::*;
#(
  parameter int EXP_WIDTH  = FP_EXP_W,
  parameter int FRAC_WIDTH = FP_FRAC_W
) (
  input  logic [EXP_WIDTH-1:0]  i_exp,
  input  logic [FRAC_WIDTH-1:0] i_frac,
  output fp_cls_e               o_cls
);

  logic w_zero;
  logic w_top;
  logic w_fnz;

  assign w_zero = ~|i_exp;
  assign w_top  = &i_exp;
  assign w_fnz  = |i_frac;

  // Exclusive class decode, subnormals fold into zero
  always_comb begin
    o_cls = NORM;
    unique case (1'b1)
      w_zero:          o_cls = ZERO;
      w_top & ~w_fnz:  o_cls = INF;
      w_top & w_fnz:   o_cls = NAN;
      default:         o_cls = NORM;
    endcase
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined FP multiplier with valid/ready flow control.
// FP_MUL_PIPE_RNE_EN selects round-to-nearest-even, else truncation.
module fp_mul_pipe
  import fp_mul_pipe_pkg::*;
#(
  parameter int EXP_WIDTH  = FP_EXP_W,
  parameter int FRAC_WIDTH = FP_FRAC_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0]     op1,
  input  logic [EXP_WIDTH+FRAC_WIDTH:0]     op2,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXP_WIDTH+FRAC_WIDTH:0]     result,
  output logic [3:0]                        flags
);

  localparam int E  = EXP_WIDTH;
  localparam int F  = FRAC_WIDTH;
  localparam int W  = 1 + E + F;
  localparam int EW = E + 2;
  localparam int MW = F + 1;
  localparam int PW = 2 * MW;

  localparam logic signed [EW-1:0] C_BIAS =
    EW'(f_bias(E));
  localparam logic signed [EW-1:0] C_EMAX =
    EW'((1 << E) - 1);
  localparam logic signed [EW-1:0] C_ONE = EW'(1);

  localparam logic [W-1:0] C_QNAN =
    {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
  localparam logic [W-2:0] C_INF_MAG =
    {{E{1'b1}}, {F{1'b0}}};

  // ---------------- flow control ----------------
  logic w_adv1;
  logic w_adv2;
  logic w_adv3;

  logic r1_valid;
  logic r2_valid;
  logic r3_valid;

  assign w_adv3   = ~r3_valid | out_ready;
  assign w_adv2   = ~r2_valid | w_adv3;
  assign w_adv1   = ~r1_valid | w_adv2;
  assign in_ready = w_adv1;

  // ---------------- stage 1 ----------------
  logic         w_s1;
  logic         w_s2;
  logic [E-1:0] w_e1;
  logic [E-1:0] w_e2;
  logic [F-1:0] w_f1;
  logic [F-1:0] w_f2;
  fp_cls_e      w_c1;
  fp_cls_e      w_c2;

  assign w_s1 = op1[W-1];
  assign w_e1 = op1[W-2:F];
  assign w_f1 = op1[F-1:0];
  assign w_s2 = op2[W-1];
  assign w_e2 = op2[W-2:F];
  assign w_f2 = op2[F-1:0];

  fp_classify #(
    .EXP_WIDTH  (E),
    .FRAC_WIDTH (F)
  ) u_cls1 (
    .i_exp  (w_e1),
    .i_frac (w_f1),
    .o_cls  (w_c1)
  );

  fp_classify #(
    .EXP_WIDTH  (E),
    .FRAC_WIDTH (F)
  ) u_cls2 (
    .i_exp  (w_e2),
    .i_frac (w_f2),
    .o_cls  (w_c2)
  );

  logic w_sign;
  logic w_any_nan;
  logic w_any_inf;
  logic w_any_zero;
  logic w_is_inv;
  logic w_is_inf;
  logic w_is_zero;

  assign w_sign     = w_s1 ^ w_s2;
  assign w_any_nan  = (w_c1 == NAN) | (w_c2 == NAN);
  assign w_any_inf  = (w_c1 == INF) | (w_c2 == INF);
  assign w_any_zero = (w_c1 == ZERO) | (w_c2 == ZERO);

  assign w_is_inv  = ~w_any_nan & w_any_inf & w_any_zero;
  assign w_is_inf  = ~w_any_nan & w_any_inf & ~w_any_zero;
  assign w_is_zero = ~w_any_nan & w_any_zero & ~w_any_inf;

  logic         w_sp;
  logic         w_sp_inv;
  logic [W-1:0] w_sp_res;

  // Special-operand result, NaN dominates everything
  always_comb begin
    w_sp     = 1'b1;
    w_sp_inv = 1'b0;
    w_sp_res = '0;
    unique case (1'b1)
      w_any_nan: w_sp_res = C_QNAN;
      w_is_inv: begin
        w_sp_res = C_QNAN;
        w_sp_inv = 1'b1;
      end
      w_is_inf:  w_sp_res = {w_sign, C_INF_MAG};
      w_is_zero: w_sp_res = {w_sign, {(W-1){1'b0}}};
      default:   w_sp     = 1'b0;
    endcase
  end

  logic signed [EW-1:0] w_e_sum;

  assign w_e_sum = EW'(w_e1) + EW'(w_e2) - C_BIAS;

  logic                 r1_sp;
  logic                 r1_sp_inv;
  logic [W-1:0]         r1_sp_res;
  logic                 r1_sign;
  logic signed [EW-1:0] r1_exp;
  logic [MW-1:0]        r1_m1;
  logic [MW-1:0]        r1_m2;

  // Stage 1 register: class outcome, exponent sum, mantissas
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid  <= 1'b0;
      r1_sp     <= 1'b0;
      r1_sp_inv <= 1'b0;
      r1_sp_res <= '0;
      r1_sign   <= 1'b0;
      r1_exp    <= '0;
      r1_m1     <= '0;
      r1_m2     <= '0;
    end else if (w_adv1) begin
      r1_valid <= in_valid;
      if (in_valid) begin
        r1_sp     <= w_sp;
        r1_sp_inv <= w_sp_inv;
        r1_sp_res <= w_sp_res;
        r1_sign   <= w_sign;
        r1_exp    <= w_e_sum;
        r1_m1     <= {1'b1, w_f1};
        r1_m2     <= {1'b1, w_f2};
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [PW-1:0]        w_prod;
  logic                 w_hi;
  logic [F-1:0]         w_frac2;
  logic                 w_guard2;
  logic                 w_sticky2;
  logic signed [EW-1:0] w_exp2;

  assign w_prod = {{(PW-MW){1'b0}}, r1_m1}
                * {{(PW-MW){1'b0}}, r1_m2};
  assign w_hi   = w_prod[PW-1];

  // Normalise into [1,2) and split off guard/sticky
  always_comb begin
    if (w_hi) begin
      w_frac2   = w_prod[2*F -: F];
      w_guard2  = w_prod[F];
      w_sticky2 = |w_prod[F-1:0];
    end else begin
      w_frac2   = w_prod[2*F-1 -: F];
      w_guard2  = w_prod[F-1];
      w_sticky2 = |w_prod[F-2:0];
    end
  end

  assign w_exp2 = r1_exp + EW'(w_hi);

  logic                 r2_sp;
  logic                 r2_sp_inv;
  logic [W-1:0]         r2_sp_res;
  logic                 r2_sign;
  logic signed [EW-1:0] r2_exp;
  logic [F-1:0]         r2_frac;
  logic                 r2_guard;
  logic                 r2_sticky;

  // Stage 2 register: normalised mantissa and round bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid  <= 1'b0;
      r2_sp     <= 1'b0;
      r2_sp_inv <= 1'b0;
      r2_sp_res <= '0;
      r2_sign   <= 1'b0;
      r2_exp    <= '0;
      r2_frac   <= '0;
      r2_guard  <= 1'b0;
      r2_sticky <= 1'b0;
    end else if (w_adv2) begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sp     <= r1_sp;
        r2_sp_inv <= r1_sp_inv;
        r2_sp_res <= r1_sp_res;
        r2_sign   <= r1_sign;
        r2_exp    <= w_exp2;
        r2_frac   <= w_frac2;
        r2_guard  <= w_guard2;
        r2_sticky <= w_sticky2;
      end
    end
  end

  // ---------------- stage 3 ----------------
  logic [F-1:0]         w_frac3;
  logic signed [EW-1:0] w_exp3;

`ifdef FP_MUL_PIPE_RNE_EN
  logic         w_inc;
  logic [F:0]   w_sum;

  assign w_inc   = r2_guard & (r2_sticky | r2_frac[0]);
  assign w_sum   = {1'b0, r2_frac} + {{F{1'b0}}, w_inc};
  assign w_frac3 = w_sum[F-1:0];
  assign w_exp3  = r2_exp + EW'(w_sum[F]);
`else
  assign w_frac3 = r2_frac;
  assign w_exp3  = r2_exp;
`endif

  logic [W-1:0] w_res;
  logic [3:0]   w_flg;

  // Pack result, saturating to inf or flushing to zero
  always_comb begin
    w_res = {r2_sign, w_exp3[E-1:0], w_frac3};
    w_flg = {3'b000, r2_guard | r2_sticky};
    if (r2_sp) begin
      w_res = r2_sp_res;
      w_flg = {r2_sp_inv, 3'b000};
    end else if (w_exp3 >= C_EMAX) begin
      w_res = {r2_sign, C_INF_MAG};
      w_flg = 4'b0101;
    end else if (w_exp3 < C_ONE) begin
      w_res = {r2_sign, {(W-1){1'b0}}};
      w_flg = 4'b0011;
    end
  end

  logic [W-1:0] r3_result;
  logic [3:0]   r3_flags;

  // Stage 3 register: held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_valid  <= 1'b0;
      r3_result <= '0;
      r3_flags  <= '0;
    end else if (w_adv3) begin
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_result <= w_res;
        r3_flags  <= w_flg;
      end
    end
  end

  assign out_valid = r3_valid;
  assign result    = r3_result;
  assign flags     = r3_flags;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed table, random stream with
// scoreboard, backpressure and mid-flight reset sequences.
module tb_fp_mul_pipe;
  import fp_mul_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] op1 = '0;
  logic [15:0] op2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] result;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h",
               name, act, exp);
    end
  endfunction

  // Reference: exact integer product, rounded by remainder
  function automatic void model(input logic [15:0] a,
                                input logic [15:0] b,
                                output logic [15:0] r,
                                output logic [3:0] fl);
    int ea, eb, fa, fb, p, e, sh, q, rem, half;
    bit s, na, nb, ia, ib, za, zb, inx;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    fa = int'(a[6:0]);
    fb = int'(b[6:0]);
    s  = a[15] ^ b[15];
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    za = (ea == 0);
    zb = (eb == 0);
    fl = 4'b0000;
    if (na || nb) begin
      r = 16'h7FC0;
    end else if ((ia && zb) || (za && ib)) begin
      r  = 16'h7FC0;
      fl = 4'b1000;
    end else if (ia || ib) begin
      r = {s, 15'h7F80};
    end else if (za || zb) begin
      r = {s, 15'h0000};
    end else begin
      p  = (128 + fa) * (128 + fb);
      e  = ea + eb - 127;
      sh = 7;
      if (p >= 32768) begin
        sh = 8;
        e  = e + 1;
      end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 1 << (sh - 1);
      inx  = (rem != 0);
`ifdef FP_MUL_PIPE_RNE_EN
      if (rem > half || (rem == half && q % 2 == 1))
        q = q + 1;
`endif
      if (q == 256) begin
        q = 128;
        e = e + 1;
      end
      if (e >= 255) begin
        r  = {s, 15'h7F80};
        fl = 4'b0101;
      end else if (e <= 0) begin
        r  = {s, 15'h0000};
        fl = 4'b0011;
      end else begin
        r  = {s, e[7:0], q[6:0]};
        fl = {3'b000, inx};
      end
    end
  endfunction

  function automatic logic [15:0] rand_op();
    fp_t v;
    int  sel;
    sel    = $urandom_range(0, 15);
    v.sign = 1'($urandom_range(0, 1));
    v.frac = 7'($urandom);
    case (sel)
      0:       v.exp = 8'h00;
      1:       v.exp = 8'hFF;
      2:       begin v.exp = 8'hFF; v.frac = '0; end
      3, 4:    v.exp = 8'($urandom_range(190, 254));
      5, 6:    v.exp = 8'($urandom_range(1, 64));
      default: v.exp = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // ---------------- streaming scoreboard ----------------
  logic [15:0] pend_a[$];
  logic [15:0] pend_b[$];
  logic [15:0] exp_r[$];
  logic [3:0]  exp_f[$];
  int          n_acc = 0;
  int          n_out = 0;
  bit          gap_en = 1'b0;
  bit          rdy_rand = 1'b0;
  bit          held = 1'b0;
  logic [15:0] held_r = '0;
  logic [3:0]  held_f = '0;

  task automatic load_inputs();
    in_valid = (pend_a.size() > 0);
    if (gap_en && $urandom_range(0, 3) == 0)
      in_valid = 1'b0;
    if (pend_a.size() > 0) begin
      op1 = pend_a[0];
      op2 = pend_b[0];
    end
  endtask

  task automatic step();
    logic [15:0] r;
    logic [3:0]  f;
    @(negedge clk);
    if (held) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'(result), 32'(held_r));
      chk("hold_flags", 32'(flags), 32'(held_f));
    end
    held   = out_valid && !out_ready;
    held_r = result;
    held_f = flags;
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_r.size() == 0) begin
        chk("unexpected_out", 32'(result), 32'hFFFFFFFF);
      end else begin
        chk("stream_result", 32'(result),
            32'(exp_r.pop_front()));
        chk("stream_flags", 32'(flags),
            32'(exp_f.pop_front()));
      end
    end
    if (in_valid && in_ready) begin
      model(pend_a[0], pend_b[0], r, f);
      exp_r.push_back(r);
      exp_f.push_back(f);
      void'(pend_a.pop_front());
      void'(pend_b.pop_front());
      n_acc++;
    end
    @(posedge clk);
    #1;
    if (rdy_rand)
      out_ready = ($urandom_range(0, 3) != 0);
    load_inputs();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[13];

  task automatic run_vec(input logic [15:0] a,
                         input logic [15:0] b,
                         output logic [15:0] r,
                         output logic [3:0] f,
                         output int lat);
    out_ready = 1'b1;
    op1       = a;
    op2       = b;
    in_valid  = 1'b1;
    #1;
    chk("vec_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid)
      chk("vec_timeout", 32'(lat), 32'd3);
    r = result;
    f = flags;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] r;
    logic [3:0]  f;
    int          lat;
    int          cyc;

    vecs[0]  = '{16'h3F80, 16'h3F80, 16'h3F80, 4'b0000};
    vecs[1]  = '{16'h3FC0, 16'h3FC0, 16'h4010, 4'b0000};
`ifdef FP_MUL_PIPE_RNE_EN
    vecs[2]  = '{16'h3FC1, 16'h3FC1, 16'h4012, 4'b0001};
`else
    vecs[2]  = '{16'h3FC1, 16'h3FC1, 16'h4011, 4'b0001};
`endif
    vecs[3]  = '{16'h7F80, 16'h0000, 16'h7FC0, 4'b1000};
    vecs[4]  = '{16'hFF80, 16'h4000, 16'hFF80, 4'b0000};
    vecs[5]  = '{16'h7FC1, 16'h3F80, 16'h7FC0, 4'b0000};
    vecs[6]  = '{16'h7F00, 16'h4000, 16'h7F80, 4'b0101};
    vecs[7]  = '{16'h0080, 16'h0080, 16'h0000, 4'b0011};
    vecs[8]  = '{16'h8000, 16'h3F80, 16'h8000, 4'b0000};
    vecs[9]  = '{16'h0001, 16'h3F80, 16'h0000, 4'b0000};
    vecs[10] = '{16'hC000, 16'h4000, 16'hC080, 4'b0000};
    vecs[11] = '{16'h7F80, 16'hFF80, 16'hFF80, 4'b0000};
    vecs[12] = '{16'h7FC0, 16'h0000, 16'h7FC0, 4'b0000};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // directed vectors
    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i].a, vecs[i].b, r, f, lat);
      chk($sformatf("vec%0d_result", i),
          32'(r), 32'(vecs[i].res));
      chk($sformatf("vec%0d_flags", i),
          32'(f), 32'(vecs[i].flg));
      if (i < 2)
        chk($sformatf("vec%0d_latency", i),
            32'(lat), 32'd3);
    end

    // random stream with gaps and random stalls
    for (int i = 0; i < 300; i++) begin
      pend_a.push_back(rand_op());
      pend_b.push_back(rand_op());
    end
    n_out    = 0;
    gap_en   = 1'b1;
    rdy_rand = 1'b1;
    out_ready = 1'b1;
    load_inputs();
    cyc = 0;
    while ((pend_a.size() > 0 || exp_r.size() > 0)
           && cyc < 5000) begin
      step();
      cyc++;
    end
    chk("rand_drained", 32'(exp_r.size()), 32'd0);
    chk("rand_count", 32'(n_out), 32'd300);

    // backpressure: full pipe holds exactly 3
    gap_en    = 1'b0;
    rdy_rand  = 1'b0;
    out_ready = 1'b0;
    held      = 1'b0;
    n_acc     = 0;
    n_out     = 0;
    for (int i = 0; i < 6; i++) begin
      pend_a.push_back(16'h3F80 + 16'(i * 16'h0011));
      pend_b.push_back(16'h4000 + 16'(i * 16'h0023));
    end
    load_inputs();
    repeat (5) step();
    chk("bp_accepts", 32'(n_acc), 32'd3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    cyc = 0;
    while (n_out < 6 && cyc < 50) begin
      step();
      cyc++;
    end
    chk("bp_outputs", 32'(n_out), 32'd6);
    chk("bp_accepts_all", 32'(n_acc), 32'd6);
    repeat (3) step();
    chk("bp_no_dup", 32'(n_out), 32'd6);

    // reset with three entries in flight
    out_ready = 1'b0;
    held      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pend_a.push_back(16'h4040);
      pend_b.push_back(16'h4040 + 16'(i));
    end
    load_inputs();
    repeat (3) step();
    chk("mid_full", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_flags", 32'(flags), 32'd0);
    exp_r.delete();
    exp_f.delete();
    pend_a.delete();
    pend_b.delete();
    in_valid = 1'b0;
    held     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    n_out     = 0;
    repeat (10) step();
    chk("mid_no_stale", 32'(n_out), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
